// File: rtl/ap_ctrl_stats_monitor.sv
// Per-channel ap_ctrl_hs / ap_ctrl_chain handshake monitor: transaction/latency/busy statistics,
// hang watchdog, freeze-on-finish and a registered read port.
module ap_ctrl_stats_monitor #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              finish_i,
    input  logic [NUM_CH-1:0] ap_start_i,
    input  logic [NUM_CH-1:0] ap_ready_i,
    input  logic [NUM_CH-1:0] ap_done_i,
    input  logic [NUM_CH-1:0] ap_continue_i,
    input  logic              rd_en_i,
    input  logic [3:0]        rd_ch_i,
    input  logic [2:0]        rd_field_i,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic              rd_valid_o,
    output logic [NUM_CH-1:0] hang_o,
    output logic              all_idle_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StHold = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CntOne;
    endfunction

    state_e           state_q    [NUM_CH];
    state_e           state_d    [NUM_CH];
    logic [CNT_W-1:0] lat_ctr_q  [NUM_CH];
    logic [CNT_W-1:0] lat_ctr_d  [NUM_CH];
    logic [CNT_W-1:0] txn_cnt_q  [NUM_CH];
    logic [CNT_W-1:0] txn_cnt_d  [NUM_CH];
    logic [CNT_W-1:0] last_lat_q [NUM_CH];
    logic [CNT_W-1:0] last_lat_d [NUM_CH];
    logic [CNT_W-1:0] min_lat_q  [NUM_CH];
    logic [CNT_W-1:0] min_lat_d  [NUM_CH];
    logic [CNT_W-1:0] max_lat_q  [NUM_CH];
    logic [CNT_W-1:0] max_lat_d  [NUM_CH];
    logic [CNT_W-1:0] busy_cyc_q [NUM_CH];
    logic [CNT_W-1:0] busy_cyc_d [NUM_CH];
    logic [CNT_W-1:0] ready_q    [NUM_CH];
    logic [CNT_W-1:0] ready_d    [NUM_CH];
    logic             rec        [NUM_CH];
    logic [CNT_W-1:0] rec_lat    [NUM_CH];
    logic [NUM_CH-1:0] hang_q, hang_d;

    logic             freeze_q;
    logic             frozen;
    logic [CNT_W-1:0] rd_sel;
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_valid_q;

    // The first finish cycle already freezes; freeze_q keeps it frozen afterwards.
    assign frozen = finish_i | freeze_q;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]    = state_q[c];
            lat_ctr_d[c]  = lat_ctr_q[c];
            txn_cnt_d[c]  = txn_cnt_q[c];
            last_lat_d[c] = last_lat_q[c];
            min_lat_d[c]  = min_lat_q[c];
            max_lat_d[c]  = max_lat_q[c];
            busy_cyc_d[c] = busy_cyc_q[c];
            ready_d[c]    = ready_q[c];
            hang_d[c]     = hang_q[c];
            rec[c]        = 1'b0;
            rec_lat[c]    = '0;

            unique case (state_q[c])
                StIdle: begin
                    if (ap_start_i[c]) begin
                        lat_ctr_d[c] = '0;
                        if (ap_done_i[c]) begin
                            // Zero-latency transaction: never passes through BUSY.
                            rec[c]     = 1'b1;
                            rec_lat[c] = '0;
                            if (ap_continue_i[c]) begin
                                txn_cnt_d[c] = sat_inc(txn_cnt_q[c]);
                            end else begin
                                state_d[c] = StHold;
                            end
                        end else begin
                            state_d[c] = StBusy;
                        end
                    end
                end
                StBusy: begin
                    lat_ctr_d[c] = sat_inc(lat_ctr_q[c]);
                    if (lat_ctr_d[c] == TimeoutCnt) begin
                        hang_d[c] = 1'b1;
                    end
                    if (ap_done_i[c]) begin
                        rec[c]     = 1'b1;
                        rec_lat[c] = lat_ctr_d[c];
                        if (ap_continue_i[c]) begin
                            txn_cnt_d[c] = sat_inc(txn_cnt_q[c]);
                            state_d[c]   = StIdle;
                        end else begin
                            state_d[c] = StHold;
                        end
                    end
                end
                StHold: begin
                    if (ap_continue_i[c]) begin
                        txn_cnt_d[c] = sat_inc(txn_cnt_q[c]);
                        state_d[c]   = StIdle;
                    end
                end
                default: state_d[c] = StIdle;
            endcase

            if (rec[c]) begin
                last_lat_d[c] = rec_lat[c];
                if (rec_lat[c] < min_lat_q[c]) begin
                    min_lat_d[c] = rec_lat[c];
                end
                if (rec_lat[c] > max_lat_q[c]) begin
                    max_lat_d[c] = rec_lat[c];
                end
            end
            if (state_q[c] != StIdle) begin
                busy_cyc_d[c] = sat_inc(busy_cyc_q[c]);
            end
            if (ap_start_i[c] && ap_ready_i[c]) begin
                ready_d[c] = sat_inc(ready_q[c]);
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch_i == 4'(c)) begin
                case (rd_field_i)
                    3'd0: rd_sel = txn_cnt_q[c];
                    3'd1: rd_sel = last_lat_q[c];
                    3'd2: rd_sel = min_lat_q[c];
                    3'd3: rd_sel = max_lat_q[c];
                    3'd4: rd_sel = busy_cyc_q[c];
                    3'd5: rd_sel = ready_q[c];
                    3'd6: begin
                        rd_sel[1:0] = state_q[c];
                        rd_sel[2]   = hang_q[c];
                    end
                    default: rd_sel = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]    <= StIdle;
                lat_ctr_q[c]  <= '0;
                txn_cnt_q[c]  <= '0;
                last_lat_q[c] <= '0;
                min_lat_q[c]  <= CntMax;
                max_lat_q[c]  <= '0;
                busy_cyc_q[c] <= '0;
                ready_q[c]    <= '0;
            end
            hang_q     <= '0;
            freeze_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (finish_i) begin
                freeze_q <= 1'b1;
            end
            if (!frozen) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    state_q[c]    <= state_d[c];
                    lat_ctr_q[c]  <= lat_ctr_d[c];
                    txn_cnt_q[c]  <= txn_cnt_d[c];
                    last_lat_q[c] <= last_lat_d[c];
                    min_lat_q[c]  <= min_lat_d[c];
                    max_lat_q[c]  <= max_lat_d[c];
                    busy_cyc_q[c] <= busy_cyc_d[c];
                    ready_q[c]    <= ready_d[c];
                end
                hang_q <= hang_d;
            end
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= rd_sel;
            end
        end
    end

    always_comb begin
        all_idle_o = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (state_q[c] != StIdle) begin
                all_idle_o = 1'b0;
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign hang_o     = hang_q;

endmodule

// File: tb/tb_ap_ctrl_stats_monitor.sv
// Directed self-checking bench for ap_ctrl_stats_monitor (4 channels, 32-bit counters, TIMEOUT=16).
module tb_ap_ctrl_stats_monitor;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              finish;
    logic [NUM_CH-1:0] ap_start;
    logic [NUM_CH-1:0] ap_ready;
    logic [NUM_CH-1:0] ap_done;
    logic [NUM_CH-1:0] ap_continue;
    logic              rd_en;
    logic [3:0]        rd_ch;
    logic [2:0]        rd_field;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_valid;
    logic [NUM_CH-1:0] hang;
    logic              all_idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ap_ctrl_stats_monitor #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .finish_i     (finish),
        .ap_start_i   (ap_start),
        .ap_ready_i   (ap_ready),
        .ap_done_i    (ap_done),
        .ap_continue_i(ap_continue),
        .rd_en_i      (rd_en),
        .rd_ch_i      (rd_ch),
        .rd_field_i   (rd_field),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .hang_o       (hang),
        .all_idle_o   (all_idle)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one read; consecutive calls keep rd_en high, giving back-to-back reads.
    task automatic rd(input int ch, input int f, output logic [31:0] data);
        rd_en    = 1'b1;
        rd_ch    = 4'(ch);
        rd_field = 3'(f);
        step();
        rd_en = 1'b0;
        data  = rd_data;
        checks++;
        if (rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd_valid ch%0d f%0d: got %b want 1", ch, f, rd_valid);
        end
    endtask

    task automatic run_txn(input int ch, input int lat);
        ap_start[ch] = 1'b1;
        step();
        ap_start[ch] = 1'b0;
        repeat (lat - 1) step();
        ap_done[ch] = 1'b1;
        step();
        ap_done[ch] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_d;
        rst_n       = 1'b0;
        finish      = 1'b0;
        ap_start    = '0;
        ap_ready    = '0;
        ap_done     = '0;
        ap_continue = '1;
        rd_en       = 1'b0;
        rd_ch       = '0;
        rd_field    = '0;
        repeat (3) step();
        rst_n = 1'b1;
        checks++;
        if (all_idle !== 1'b1) begin
            errors++;
            $display("FAIL reset all_idle: got %b want 1", all_idle);
        end
        checks++;
        if (hang !== 4'b0000) begin
            errors++;
            $display("FAIL reset hang: got %b want 0000", hang);
        end
        for (int ch = 0; ch <= 4; ch++) begin
            for (int f = 0; f < 8; f++) begin
                exp_d = (f == 2 && ch < 4) ? 32'hFFFF_FFFF : 32'h0;
                rd(ch, f, d);
                checks++;
                if (d !== exp_d) begin
                    errors++;
                    $display("FAIL reset ch%0d field%0d: got %h want %h", ch, f, d, exp_d);
                end
            end
        end
        rd(0, 2, d);
        step();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL rd_hold: got valid=%b data=%h want valid=0 data=ffffffff",
                     rd_valid, rd_data);
        end
    endtask

    task automatic test_hs();
        logic [31:0] d;
        logic [31:0] exp_v [7];
        exp_v = '{32'd1, 32'd5, 32'd5, 32'd5, 32'd5, 32'd1, 32'd0};
        ap_start[0] = 1'b1;
        ap_ready[0] = 1'b1;
        step();
        ap_start[0] = 1'b0;
        ap_ready[0] = 1'b0;
        checks++;
        if (all_idle !== 1'b0) begin
            errors++;
            $display("FAIL hs busy all_idle: got %b want 0", all_idle);
        end
        repeat (4) step();
        ap_done[0] = 1'b1;
        step();
        ap_done[0] = 1'b0;
        checks++;
        if (all_idle !== 1'b1) begin
            errors++;
            $display("FAIL hs done all_idle: got %b want 1", all_idle);
        end
        for (int f = 0; f < 7; f++) begin
            rd(0, f, d);
            checks++;
            if (d !== exp_v[f]) begin
                errors++;
                $display("FAIL hs ch0 field%0d: got %0d want %0d", f, d, exp_v[f]);
            end
        end
    endtask

    task automatic test_chain();
        logic [31:0] d;
        logic [31:0] exp_v [7];
        exp_v = '{32'd1, 32'd3, 32'd3, 32'd3, 32'd7, 32'd0, 32'd0};
        ap_continue[1] = 1'b0;
        ap_start[1]    = 1'b1;
        step();
        ap_start[1] = 1'b0;
        repeat (2) step();
        ap_done[1] = 1'b1;
        step();
        for (int k = 4; k <= 6; k++) begin
            ap_done[1] = (k == 5);
            rd(1, 6, d);
            checks++;
            if (d !== 32'd2) begin
                errors++;
                $display("FAIL chain hold state cycle%0d: got %0d want 2", k, d);
            end
        end
        ap_done[1]     = 1'b0;
        ap_continue[1] = 1'b1;
        // Read in the same cycle as the completing continue still sees the old count.
        rd(1, 0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL chain same-cycle txn: got %0d want 0", d);
        end
        for (int f = 0; f < 7; f++) begin
            rd(1, f, d);
            checks++;
            if (d !== exp_v[f]) begin
                errors++;
                $display("FAIL chain ch1 field%0d: got %0d want %0d", f, d, exp_v[f]);
            end
        end
    endtask

    task automatic test_mixed();
        logic [31:0] d;
        logic [31:0] exp_v [6];
        exp_v = '{32'd3, 32'd4, 32'd2, 32'd9, 32'd15, 32'd0};
        run_txn(2, 2);
        step();
        run_txn(2, 9);
        step();
        run_txn(2, 4);
        step();
        for (int f = 0; f < 6; f++) begin
            rd(2, f, d);
            checks++;
            if (d !== exp_v[f]) begin
                errors++;
                $display("FAIL mixed ch2 field%0d: got %0d want %0d", f, d, exp_v[f]);
            end
        end
        rd(0, 0, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL mixed ch0 txn: got %0d want 1", d);
        end
        rd(1, 1, d);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL mixed ch1 last_lat: got %0d want 3", d);
        end
        rd(3, 2, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mixed ch3 min_lat: got %h want ffffffff", d);
        end
    endtask

    task automatic test_zero_lat();
        logic [31:0] d;
        logic [31:0] exp_v [7];
        exp_v = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        ap_start[3] = 1'b1;
        ap_done[3]  = 1'b1;
        step();
        ap_start[3] = 1'b0;
        ap_done[3]  = 1'b0;
        for (int f = 0; f < 7; f++) begin
            rd(3, f, d);
            checks++;
            if (d !== exp_v[f]) begin
                errors++;
                $display("FAIL zero-lat ch3 field%0d: got %0d want %0d", f, d, exp_v[f]);
            end
        end
    endtask

    task automatic test_watchdog();
        logic [31:0] d;
        logic [31:0] exp_v [7];
        exp_v = '{32'd2, 32'd20, 32'd0, 32'd20, 32'd20, 32'd0, 32'd4};
        ap_start[3] = 1'b1;
        step();
        ap_start[3] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            ap_done[3] = (k == 20);
            step();
            checks++;
            if (hang[3] !== (k >= 16)) begin
                errors++;
                $display("FAIL watchdog hang[3] cycle%0d: got %b want %b", k, hang[3], k >= 16);
            end
        end
        ap_done[3] = 1'b0;
        for (int f = 0; f < 7; f++) begin
            rd(3, f, d);
            checks++;
            if (d !== exp_v[f]) begin
                errors++;
                $display("FAIL watchdog ch3 field%0d: got %0d want %0d", f, d, exp_v[f]);
            end
        end
        checks++;
        if (hang !== 4'b1000) begin
            errors++;
            $display("FAIL watchdog hang vector: got %b want 1000", hang);
        end
    endtask

    task automatic test_finish_reset();
        logic [31:0] d;
        logic [31:0] exp_v [7];
        exp_v = '{32'd1, 32'd5, 32'd5, 32'd5, 32'd8, 32'd1, 32'd1};
        ap_start[0] = 1'b1;
        step();
        ap_start[0] = 1'b0;
        repeat (3) step();
        finish = 1'b1;
        step();
        finish = 1'b0;
        for (int k = 0; k < 50; k++) begin
            ap_done     = (k % 2 == 0) ? 4'b1111 : 4'b0000;
            ap_start[2] = (k == 10);
            ap_ready    = 4'b1111;
            step();
        end
        ap_done  = '0;
        ap_start = '0;
        ap_ready = '0;
        for (int f = 0; f < 7; f++) begin
            rd(0, f, d);
            checks++;
            if (d !== exp_v[f]) begin
                errors++;
                $display("FAIL frozen ch0 field%0d: got %0d want %0d", f, d, exp_v[f]);
            end
        end
        rd(2, 0, d);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL frozen ch2 txn: got %0d want 3", d);
        end
        rd(2, 5, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL frozen ch2 ready_cnt: got %0d want 0", d);
        end
        checks++;
        if (hang !== 4'b1000 || all_idle !== 1'b0) begin
            errors++;
            $display("FAIL frozen flags: got hang=%b all_idle=%b want hang=1000 all_idle=0",
                     hang, all_idle);
        end

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_v = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        checks++;
        if (hang !== 4'b0000 || all_idle !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL post-reset flags: got hang=%b all_idle=%b rd_valid=%b want 0000/1/0",
                     hang, all_idle, rd_valid);
        end
        for (int f = 0; f < 7; f++) begin
            rd(0, f, d);
            checks++;
            if (d !== exp_v[f]) begin
                errors++;
                $display("FAIL post-reset ch0 field%0d: got %h want %h", f, d, exp_v[f]);
            end
        end
        run_txn(0, 3);
        rd(0, 0, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL unfrozen ch0 txn: got %0d want 1", d);
        end
        rd(0, 1, d);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL unfrozen ch0 last_lat: got %0d want 3", d);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_hs();
        test_chain();
        test_mixed();
        test_zero_lat();
        test_watchdog();
        test_finish_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
